gate_arbiter: RTL
=================

# gate_arbiter

Round-robin arbiter and sequencer that shares one registered bitwise gate unit (NAND, NOT, AND, OR, XOR) among N requesters. Each requester presents an opcode and two operand words and holds a request line. The arbiter grants one requester at a time, latches its operands, computes the result and returns it with a one-cycle valid strobe. It sits between the gate library and client blocks that would otherwise each instantiate their own wide gate array.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 16, operand/result word width
- IDW, 2, width of requester index; must satisfy 2^IDW >= N_REQ
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset; sampled on rising edge of clk
- req  input  N_REQ  request lines; bit i belongs to requester i, level-held
- op  input  3*N_REQ  opcode of requester i at bits [3i+2:3i]
- a  input  WIDTH*N_REQ  operand A of requester i at bits [WIDTH*i+WIDTH-1:WIDTH*i]
- b  input  WIDTH*N_REQ  operand B of requester i, same packing
- gnt  output  N_REQ  one-hot grant pulse, registered
- gnt_id  output  IDW  index of the requester owning the current/last operation
- y  output  WIDTH  result word, registered, held until next result
- valid  output  1  one-cycle result strobe
- err  output  1  illegal opcode flag, qualified by valid
- busy  output  1  high whenever state is not IDLE

## Operation
- Opcodes: 0 NAND (~(a&b)), 1 NOT (~a, b ignored), 2 AND, 3 OR, 4 XOR; 5..7 illegal -> y=0, err=1.
- All operations are bitwise across WIDTH bits. There is no carry and no width growth.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: if req != 0, pick the winner, set gnt to one-hot(winner) and gnt_id to winner, latch op/a/b of the winner into internal registers, then go to EXEC. Otherwise stay in IDLE.
  - EXEC: gnt <= 0, y <= f(op_r, a_r, b_r), err <= (op_r > 4), valid <= 1, go to DONE.
  - DONE: valid <= 0, err holds, ptr <= gnt_id, go to IDLE.
- Winner selection: ptr is the index of the last served requester. Search starts at (ptr+1) mod N_REQ and increments, wrapping; the first set req bit wins.
- Requester protocol:
  - Hold req, op, a and b stable until gnt[i] is seen.
  - Operands are captured on the grant edge, so they may change afterward.
  - Drop req no later than the clock edge after valid is seen with gnt_id == i. A req still high when the FSM re-enters IDLE is treated as a new request.
- Requests arriving while busy are ignored until IDLE and are never lost, because they are level-held.
- A req bit that drops before being granted is simply not served.

## Timing
- Reset values: state IDLE, gnt 0, gnt_id 0, y 0, valid 0, err 0, busy 0.
- ptr resets to N_REQ-1, so requester 0 has first priority after reset.
- Latency: req sampled at edge k (IDLE) -> gnt high in cycle k..k+1, valid and y in cycle k+1..k+2, next possible grant at edge k+3.
- Throughput: one operation per 3 cycles. With all requesters active, every requester is served once per 3*N_REQ cycles.
- busy rises with gnt (edge k) and falls at edge k+2.
- gnt and valid are never high in the same cycle. Exactly one valid follows each gnt unless reset intervenes.
- Simultaneous requests: only one grant per IDLE visit, chosen by rotating priority. No requester waits more than N_REQ-1 other grants.
- Reset mid-operation (in EXEC or DONE): the operation is abandoned, no valid is issued, and all outputs and ptr take their reset values on that edge.
- y and gnt_id hold their last values through IDLE until the next EXEC or grant.

## Test plan
- Reset then single request: req=0001, op0=0 (NAND), a0=16'h00FF, b0=16'h0F0F -> gnt=0001 one cycle, then valid=1 with y=16'hFFF0, gnt_id=0, err=0.
- Opcode sweep on requester 2: a=16'hAAAA, b=16'hCCCC, ops 0..4 -> y = 7777, 5555, 8888, EEEE, 6666. Op 6 -> y=0000, err=1.
- Fairness: req=1111 held continuously for 12 grants -> gnt_id sequence 0,1,2,3,0,1,2,3,… with one grant every 3 cycles and no id repeated before all others are served.
- Priority rotation: serve id 2, then req=0101 -> id 0 granted next. Then with req=0101 again -> id 2 granted.
- Late request: req3 asserted during EXEC of id 1 -> id 3 is granted at the first IDLE edge. busy stays low only for that one IDLE cycle.
- Reset mid-op: drive rst_n=0 in the EXEC cycle -> no valid pulse, gnt=0, y=0. After release, req=0010 -> id 1 granted normally. A simultaneous req=0011 after reset -> id 0 wins.

Source files
------------

// File: rtl/gate_arbiter_if.sv
// Request/result bundle between N client blocks and the shared gate arbiter.
// Packed per-requester fields: requester i owns op[3i+:3], a[WIDTH*i+:WIDTH], b[WIDTH*i+:WIDTH].
interface gate_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 16,
   parameter int IDW   = 2
);
   logic [N_REQ-1:0]       req;
   logic [3*N_REQ-1:0]     op;
   logic [WIDTH*N_REQ-1:0] a;
   logic [WIDTH*N_REQ-1:0] b;
   logic [N_REQ-1:0]       gnt;
   logic [IDW-1:0]         gnt_id;
   logic [WIDTH-1:0]       y;
   logic                   valid;
   logic                   err;
   logic                   busy;

   // Handshake: a requester holds req/op/a/b until it sees its gnt bit.
   // Its result comes back later as a one-cycle valid with gnt_id equal to
   // its index. req is level-held, so one still high on return to IDLE
   // counts as a new request.
   modport master (
      output req, op, a, b,
      input  gnt, gnt_id, y, valid, err, busy
   );

   modport slave (
      input  req, op, a, b,
      output gnt, gnt_id, y, valid, err, busy
   );
endinterface

// File: rtl/gate_arbiter.sv
// Round-robin arbiter sharing one registered bitwise gate unit among N_REQ clients.
// Sequence per operation: IDLE (grant + latch) -> EXEC (compute, valid) -> DONE (advance ptr).
module gate_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 16,
   parameter int IDW   = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   gate_arbiter_if.slave bus,
   output logic [1:0]    dbg_state_o
);

   localparam int PW = IDW + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [IDW-1:0]   gnt_id_q, gnt_id_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;

   logic [PW-1:0]    cand;
   logic [IDW-1:0]   cand_id;
   logic             win_found;
   logic [IDW-1:0]   win_id;
   logic [2:0]       op_sel;
   logic [WIDTH-1:0] a_sel;
   logic [WIDTH-1:0] b_sel;
   logic [WIDTH-1:0] alu_y;
   logic             alu_err;

   // Rotating search from ptr+1; one spare bit keeps ptr+k from wrapping
   // before the explicit modulo-N_REQ subtraction.
   always_comb begin
      cand      = '0;
      cand_id   = '0;
      win_found = 1'b0;
      win_id    = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = {1'b0, ptr_q} + PW'(k);
         if (cand >= PW'(N_REQ)) begin
            cand = cand - PW'(N_REQ);
         end
         cand_id = cand[IDW-1:0];
         if (!win_found && bus.req[cand_id]) begin
            win_found = 1'b1;
            win_id    = cand_id;
         end
      end
   end

   always_comb begin
      op_sel = bus.op[int'(win_id) * 3 +: 3];
      a_sel  = bus.a[int'(win_id) * WIDTH +: WIDTH];
      b_sel  = bus.b[int'(win_id) * WIDTH +: WIDTH];
   end

   always_comb begin
      alu_y   = '0;
      alu_err = 1'b0;
      case (op_q)
         3'd0:    alu_y = ~(a_q & b_q);
         3'd1:    alu_y = ~a_q;
         3'd2:    alu_y = a_q & b_q;
         3'd3:    alu_y = a_q | b_q;
         3'd4:    alu_y = a_q ^ b_q;
         default: begin
            alu_y   = '0;
            alu_err = 1'b1;
         end
      endcase
   end

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      gnt_id_d = gnt_id_q;
      ptr_d    = ptr_q;
      y_d      = y_q;
      valid_d  = valid_q;
      err_d    = err_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      case (state_q)
         S_IDLE: begin
            if (win_found) begin
               gnt_d    = N_REQ'(1) << win_id;
               gnt_id_d = win_id;
               op_d     = op_sel;
               a_d      = a_sel;
               b_d      = b_sel;
               state_d  = S_EXEC;
            end
         end
         S_EXEC: begin
            gnt_d   = '0;
            y_d     = alu_y;
            err_d   = alu_err;
            valid_d = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: begin
            // ptr only advances once the result is out, so an abandoned
            // operation (reset) never moves priority.
            valid_d = 1'b0;
            ptr_d   = gnt_id_q;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         gnt_q    <= '0;
         gnt_id_q <= '0;
         ptr_q    <= IDW'(N_REQ - 1);
         y_q      <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         gnt_id_q <= gnt_id_d;
         ptr_q    <= ptr_d;
         y_q      <= y_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.gnt_id  = gnt_id_q;
   assign bus.y       = y_q;
   assign bus.valid   = valid_q;
   assign bus.err     = err_q;
   assign bus.busy    = (state_q != S_IDLE);
   assign dbg_state_o = state_q;

endmodule
